// File: rtl/seven_segment.sv
// Time-multiplexed common-anode seven-segment driver: scans one digit per
// INTERVAL cycles and decodes its hex nibble to active-low cathodes with DP.
module seven_segment #(
  parameter int NUM_SEGMENTS = 8,
  parameter int CLK_PER      = 10,
  parameter int REFR_RATE    = 1000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_SEGMENTS-1:0][3:0]     encoded,
  input  logic [NUM_SEGMENTS-1:0]          digit_point,
  output logic [NUM_SEGMENTS-1:0]          anode,
  output logic [7:0]                       cathode
);

  localparam int INTERVAL_RAW = 1_000_000_000 / (CLK_PER * REFR_RATE);
  localparam int INTERVAL     = (INTERVAL_RAW < 1) ? 1 : INTERVAL_RAW;
  localparam int CNT_W        = $clog2(INTERVAL + 1);
  localparam int IDX_W        = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_SEGMENTS-1:0] anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(INTERVAL - 1)) begin
      cnt_d = '0;
      if (idx_q == IDX_W'(NUM_SEGMENTS - 1)) idx_d = '0;
      else                                   idx_d = idx_q + IDX_W'(1);
    end
    // Outputs come from the current index so anode and cathode always agree.
    anode_d = '1;
    for (int i = 0; i < NUM_SEGMENTS; i++) begin
      anode_d[i] = (idx_q != IDX_W'(i));
    end
    cathode_d = {digit_point[idx_q], seg7(encoded[idx_q])};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      anode_q   <= '1;
      cathode_q <= 8'hFF;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode   = anode_q;
  assign cathode = cathode_q;

endmodule

// File: tb/tb_seven_segment.sv
// Directed bench for seven_segment: reset, scan order, decode, DP, live update,
// dwell timing on a slower instance, and the single-digit configuration.
module tb_seven_segment;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: INTERVAL = 4
  logic            reset;
  logic [7:0][3:0] encoded;
  logic [7:0]      dp;
  logic [7:0]      anode;
  logic [7:0]      cathode;

  // Timing DUT: 4 digits, INTERVAL = 1000
  logic            rst_s;
  logic [3:0][3:0] enc_s;
  logic [3:0]      dp_s;
  logic [3:0]      an_s;
  logic [7:0]      ca_s;

  // Single-digit DUT shares the main reset
  logic [0:0][3:0] enc_1;
  logic [0:0]      dp_1;
  logic [0:0]      an_1;
  logic [7:0]      ca_1;

  int checks = 0;
  int errors = 0;

  seven_segment #(.NUM_SEGMENTS(8), .CLK_PER(10), .REFR_RATE(25_000_000)) u_dut (
    .clk(clk), .reset(reset), .encoded(encoded), .digit_point(dp),
    .anode(anode), .cathode(cathode)
  );

  seven_segment #(.NUM_SEGMENTS(4), .CLK_PER(10), .REFR_RATE(100_000)) u_slow (
    .clk(clk), .reset(rst_s), .encoded(enc_s), .digit_point(dp_s),
    .anode(an_s), .cathode(ca_s)
  );

  seven_segment #(.NUM_SEGMENTS(1), .CLK_PER(10), .REFR_RATE(25_000_000)) u_one (
    .clk(clk), .reset(reset), .encoded(enc_1), .digit_point(dp_1),
    .anode(an_1), .cathode(ca_1)
  );

  // Pulse reset; the next negedge sample is the first post-reset output.
  task automatic start_scan();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic scan_check(input string name, input logic [7:0][7:0] exp_ca);
    logic [7:0] exp_an;
    for (int d = 0; d < 8; d++) begin
      exp_an = ~(8'h01 << d);
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        checks++;
        if (anode !== exp_an || cathode !== exp_ca[d]) begin
          errors++;
          $display("FAIL %s digit %0d cyc %0d: anode=%h cathode=%h expected anode=%h cathode=%h",
                   name, d, c, anode, cathode, exp_an, exp_ca[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    encoded = 32'h76543210;
    dp      = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (anode !== 8'hFF || cathode !== 8'hFF || an_1 !== 1'b1 || ca_1 !== 8'hFF) begin
        errors++;
        $display("FAIL reset_hold: anode=%h cathode=%h an_1=%b ca_1=%h expected FF FF 1 FF",
                 anode, cathode, an_1, ca_1);
      end
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (anode !== 8'hFD || cathode !== 8'hF9) begin
      errors++;
      $display("FAIL reset_prescan: anode=%h cathode=%h expected FD F9", anode, cathode);
    end
    // Assert reset between edges; outputs must clear before the next posedge.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (anode !== 8'hFF || cathode !== 8'hFF) begin
      errors++;
      $display("FAIL reset_async: anode=%h cathode=%h expected FF FF", anode, cathode);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_scan();
    encoded = 32'h76543210;
    dp      = 8'hFF;
    start_scan();
    scan_check("scan", {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0});
    @(negedge clk);
    checks++;
    if (anode !== 8'hFE || cathode !== 8'hC0) begin
      errors++;
      $display("FAIL scan_wrap: anode=%h cathode=%h expected FE C0", anode, cathode);
    end
  endtask

  task automatic test_decode();
    encoded = 32'hFEDCBA98;
    dp      = 8'hFF;
    start_scan();
    scan_check("decode", {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80});
  endtask

  task automatic test_dp();
    encoded = 32'h88888888;
    dp      = 8'hFB;
    start_scan();
    scan_check("dp", {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80});
  endtask

  task automatic test_live_update();
    encoded = 32'h76543210;
    dp      = 8'hFF;
    start_scan();
    repeat (13) @(negedge clk);
    checks++;
    if (anode !== 8'hF7 || cathode !== 8'hB0) begin
      errors++;
      $display("FAIL live_before: anode=%h cathode=%h expected F7 B0", anode, cathode);
    end
    encoded[3] = 4'hA;
    #1;
    checks++;
    if (cathode !== 8'hB0) begin
      errors++;
      $display("FAIL live_registered: cathode=%h expected B0", cathode);
    end
    @(negedge clk);
    checks++;
    if (anode !== 8'hF7 || cathode !== 8'h88) begin
      errors++;
      $display("FAIL live_after: anode=%h cathode=%h expected F7 88", anode, cathode);
    end
  endtask

  task automatic test_timing();
    logic [3:0] exp_an;
    logic [7:0] exp_ca [4];
    int len;
    exp_ca = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      exp_an = ~(4'h1 << d);
      checks++;
      if (ca_s !== exp_ca[d]) begin
        errors++;
        $display("FAIL timing_cathode digit %0d: cathode=%h expected %h", d, ca_s, exp_ca[d]);
      end
      len = 0;
      while (an_s === exp_an && len < 2000) begin
        len++;
        @(negedge clk);
      end
      checks++;
      if (len != 1000) begin
        errors++;
        $display("FAIL timing_dwell digit %0d: cycles=%0d expected 1000", d, len);
      end
    end
    checks++;
    if (an_s !== 4'hE || ca_s !== 8'hC0) begin
      errors++;
      $display("FAIL timing_wrap: anode=%h cathode=%h expected E C0", an_s, ca_s);
    end
  endtask

  task automatic test_single();
    start_scan();
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (an_1 !== 1'b0 || ca_1 !== 8'h92) begin
        errors++;
        $display("FAIL single_digit: anode=%b cathode=%h expected 0 92", an_1, ca_1);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    rst_s   = 1'b1;
    encoded = '0;
    dp      = '1;
    enc_s   = 16'h3210;
    dp_s    = 4'hF;
    enc_1   = 4'h5;
    dp_1    = 1'b1;
    test_reset();
    test_scan();
    test_decode();
    test_dp();
    test_live_update();
    test_timing();
    test_single();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
